// File: rtl/hamming_decoder.sv
// Hamming(7,4) single-error-correcting decoder.
// Two register stages: stage 1 captures the codeword and its syndrome,
// stage 2 holds the corrected nibble, the error status and a saturating
// count of corrected words.
module hamming_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [6:0]       i_data,
    input  logic             i_dv,
    input  logic             i_clr_cnt,
    output logic [3:0]       o_data,
    output logic             o_dv,
    output logic             o_err,
    output logic [2:0]       o_err_pos,
    output logic [2:0]       o_syndrome,
    output logic [CNT_W-1:0] o_err_cnt
);

    // Syndrome {s2,s1,s0} of a received codeword; zero for a valid codeword.
    function automatic logic [2:0] calc_syndrome(input logic [6:0] r);
        logic s0, s1, s2;
        s0 = r[4] ^ r[0] ^ r[1] ^ r[2];
        s1 = r[5] ^ r[1] ^ r[2] ^ r[3];
        s2 = r[6] ^ r[0] ^ r[1] ^ r[3];
        return {s2, s1, s0};
    endfunction

    // Codeword bit index named by a nonzero syndrome; 0 for a clean word.
    function automatic logic [2:0] syn_to_pos(input logic [2:0] syn);
        logic [2:0] pos;
        case (syn)
            3'b101:  pos = 3'd0;
            3'b111:  pos = 3'd1;
            3'b011:  pos = 3'd2;
            3'b110:  pos = 3'd3;
            3'b001:  pos = 3'd4;
            3'b010:  pos = 3'd5;
            3'b100:  pos = 3'd6;
            default: pos = 3'd0;
        endcase
        return pos;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [6:0]       code_p1_q;
    logic [2:0]       syn_p1_q;
    logic             vld_p1_q;

    logic [3:0]       data_p2_q, data_p2_d;
    logic             err_p2_q, err_p2_d;
    logic [2:0]       pos_p2_q, pos_p2_d;
    logic [2:0]       syn_p2_q, syn_p2_d;
    logic             vld_p2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             err_p1;
    logic [2:0]       pos_p1;
    logic [6:0]       fixed_p1;

    // ---- stage 1: capture codeword, valid and syndrome ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code_p1_q <= '0;
            syn_p1_q  <= '0;
            vld_p1_q  <= 1'b0;
        end else begin
            code_p1_q <= i_data;
            syn_p1_q  <= calc_syndrome(i_data);
            vld_p1_q  <= i_dv;
        end
    end

    // ---- stage 2: correct the located bit, hold status across bubbles, count corrections ----
    always_comb begin
        err_p1    = |syn_p1_q;
        pos_p1    = syn_to_pos(syn_p1_q);
        fixed_p1  = err_p1 ? (code_p1_q ^ (7'b000_0001 << pos_p1)) : code_p1_q;

        data_p2_d = data_p2_q;
        err_p2_d  = err_p2_q;
        pos_p2_d  = pos_p2_q;
        syn_p2_d  = syn_p2_q;
        cnt_d     = cnt_q;

        if (vld_p1_q) begin
            data_p2_d = fixed_p1[3:0];
            err_p2_d  = err_p1;
            pos_p2_d  = pos_p1;
            syn_p2_d  = syn_p1_q;
        end

        // Clear wins over an increment landing on the same edge.
        if (i_clr_cnt) begin
            cnt_d = '0;
        end else if (vld_p1_q && err_p1) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Stage 2 registers; reset discards anything still in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_p2_q <= '0;
            err_p2_q  <= 1'b0;
            pos_p2_q  <= '0;
            syn_p2_q  <= '0;
            vld_p2_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            data_p2_q <= data_p2_d;
            err_p2_q  <= err_p2_d;
            pos_p2_q  <= pos_p2_d;
            syn_p2_q  <= syn_p2_d;
            vld_p2_q  <= vld_p1_q;
            cnt_q     <= cnt_d;
        end
    end

    assign o_data     = data_p2_q;
    assign o_dv       = vld_p2_q;
    assign o_err      = err_p2_q;
    assign o_err_pos  = pos_p2_q;
    assign o_syndrome = syn_p2_q;
    assign o_err_cnt  = cnt_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: a 16-bit-counter instance and a 2-bit-counter
// instance share one stimulus stream and are compared every cycle against a
// nearest-codeword reference model, plus directed vectors and corner sequences.
module tb_hamming_decoder;

    logic        clk;
    logic        rst_n;
    logic [6:0]  din;
    logic        dv;
    logic        clr;

    logic [3:0]  o_data,  o_data2;
    logic        o_dv,    o_dv2;
    logic        o_err,   o_err2;
    logic [2:0]  o_pos,   o_pos2;
    logic [2:0]  o_syn,   o_syn2;
    logic [15:0] o_cnt;
    logic [1:0]  o_cnt2;

    hamming_decoder #(.CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_dv(dv), .i_clr_cnt(clr),
        .o_data(o_data), .o_dv(o_dv), .o_err(o_err), .o_err_pos(o_pos),
        .o_syndrome(o_syn), .o_err_cnt(o_cnt)
    );

    hamming_decoder #(.CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_dv(dv), .i_clr_cnt(clr),
        .o_data(o_data2), .o_dv(o_dv2), .o_err(o_err2), .o_err_pos(o_pos2),
        .o_syndrome(o_syn2), .o_err_cnt(o_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic       m_s1_dv;
    logic [6:0] m_s1_code;
    logic       m_dv;
    logic [3:0] m_data;
    logic       m_err;
    logic [2:0] m_pos;
    logic [2:0] m_syn;
    int         m_cnt;
    int         m_cnt2;

    typedef struct {
        logic [6:0] code;
        logic [3:0] data;
        logic       err;
        logic [2:0] pos;
        logic [2:0] syn;
    } vec_t;

    vec_t vecs[9];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[0] ^ d[1] ^ d[3], d[1] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[2], d};
    endfunction

    // Decode by finding the unique codeword within distance 1 of r.
    task automatic ref_decode(input logic [6:0] r, output logic [3:0] d, output logic err,
                              output logic [2:0] pos, output logic [2:0] syn);
        logic [6:0] diff;
        syn = {r[6] ^ r[0] ^ r[1] ^ r[3], r[5] ^ r[1] ^ r[2] ^ r[3], r[4] ^ r[0] ^ r[1] ^ r[2]};
        d = 4'd0; err = 1'b0; pos = 3'd0;
        for (int n = 0; n < 16; n++) begin
            diff = enc(4'(n)) ^ r;
            if ($countones(diff) <= 1) begin
                d   = 4'(n);
                err = (diff != 7'd0);
                pos = 3'd0;
                for (int b = 0; b < 7; b++) if (diff[b]) pos = 3'(b);
            end
        end
    endtask

    task automatic model_reset();
        m_s1_dv = 0; m_s1_code = 0; m_dv = 0; m_data = 0; m_err = 0;
        m_pos = 0; m_syn = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge();
        logic [3:0] d; logic e; logic [2:0] p, s;
        if (!rst_n) begin
            model_reset();
        end else begin
            e = 1'b0;
            if (m_s1_dv) begin
                ref_decode(m_s1_code, d, e, p, s);
                m_data = d; m_err = e; m_pos = p; m_syn = s;
            end
            if (clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (m_s1_dv && e) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_dv      = m_s1_dv;
            m_s1_dv   = dv;
            m_s1_code = din;
        end
    endtask

    task automatic check_all();
        chk("o_dv",         32'(o_dv),   32'(m_dv));
        chk("o_data",       32'(o_data), 32'(m_data));
        chk("o_err",        32'(o_err),  32'(m_err));
        chk("o_err_pos",    32'(o_pos),  32'(m_pos));
        chk("o_syndrome",   32'(o_syn),  32'(m_syn));
        chk("o_err_cnt",    32'(o_cnt),  32'(m_cnt));
        chk("o_dv_w2",      32'(o_dv2),  32'(m_dv));
        chk("o_data_w2",    32'(o_data2),32'(m_data));
        chk("o_err_cnt_w2", 32'(o_cnt2), 32'(m_cnt2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    int dv_run;
    int seq2[5];

    initial begin
        vecs[0] = '{7'h4B, 4'hB, 1'b0, 3'd0, 3'b000};
        vecs[1] = '{7'h49, 4'hB, 1'b1, 3'd1, 3'b111};
        vecs[2] = '{7'h40, 4'h0, 1'b1, 3'd6, 3'b100};
        vecs[3] = '{7'h00, 4'h0, 1'b0, 3'd0, 3'b000};
        vecs[4] = '{7'h7F, 4'hF, 1'b0, 3'd0, 3'b000};
        vecs[5] = '{7'h7E, 4'hF, 1'b1, 3'd0, 3'b101};
        vecs[6] = '{7'h4A, 4'hB, 1'b1, 3'd0, 3'b101};
        vecs[7] = '{7'h5B, 4'hB, 1'b1, 3'd4, 3'b001};
        vecs[8] = '{7'h0B, 4'hB, 1'b1, 3'd6, 3'b100};
        seq2 = '{1, 2, 3, 3, 3};

        rst_n = 0; din = 7'h7F; dv = 1; clr = 0;
        model_reset();
        tick();
        tick();
        chk("rst_o_dv",   32'(o_dv),   0);
        chk("rst_o_data", 32'(o_data), 0);
        chk("rst_o_cnt",  32'(o_cnt),  0);
        rst_n = 1; dv = 0; din = 0;

        // Directed vectors, one isolated word each
        for (int i = 0; i < 9; i++) begin
            din = vecs[i].code; dv = 1;
            tick();
            chk("tbl_lat1_dv", 32'(o_dv), 0);
            dv = 0; din = $urandom_range(0, 127);
            tick();
            chk("tbl_dv",   32'(o_dv),   1);
            chk("tbl_data", 32'(o_data), 32'(vecs[i].data));
            chk("tbl_err",  32'(o_err),  32'(vecs[i].err));
            chk("tbl_pos",  32'(o_pos),  32'(vecs[i].pos));
            chk("tbl_syn",  32'(o_syn),  32'(vecs[i].syn));
            tick();
            chk("tbl_hold_data", 32'(o_data), 32'(vecs[i].data));
        end
        // vecs[1], [2], [5..8] carry errors: six corrections so far
        chk("tbl_cnt", 32'(o_cnt), 6);

        // 112 back-to-back single-bit flips
        clr = 1; tick(); clr = 0;
        dv_run = 0;
        for (int w = 0; w < 112; w++) begin
            din = enc(4'(w / 7)) ^ (7'd1 << (w % 7)); dv = 1;
            tick();
            if (w >= 1) dv_run += int'(o_dv);
        end
        dv = 0;
        tick();
        dv_run += int'(o_dv);
        tick();
        chk("b2b_dv_cycles", 32'(dv_run), 112);
        chk("b2b_cnt",       32'(o_cnt),  112);

        // Narrow counter saturation and clear priority
        clr = 1; tick(); clr = 0;
        for (int j = 0; j < 5; j++) begin
            din = enc(4'(j + 3)) ^ (7'd1 << j); dv = 1;
            tick();
            if (j >= 1) chk("sat_seq", 32'(o_cnt2), 32'(seq2[j-1]));
        end
        dv = 0;
        tick();
        chk("sat_seq", 32'(o_cnt2), 32'(seq2[4]));
        din = enc(4'h9) ^ 7'h20; dv = 1;
        tick();
        dv = 0; clr = 1;
        tick();
        clr = 0;
        chk("clr_prio_dv",  32'(o_dv),   1);
        chk("clr_prio_err", 32'(o_err),  1);
        chk("clr_prio_cnt", 32'(o_cnt2), 0);

        // Reset with two words in flight
        din = 7'h49; dv = 1; tick();
        din = 7'h40; dv = 1; tick();
        dv = 0;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all();
        chk("mid_rst_dv",   32'(o_dv),   0);
        chk("mid_rst_data", 32'(o_data), 0);
        chk("mid_rst_cnt",  32'(o_cnt),  0);
        tick();
        rst_n = 1;
        dv_run = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            dv_run += int'(o_dv);
        end
        chk("post_rst_no_dv", 32'(dv_run), 0);
        din = 7'h4B; dv = 1;
        tick();
        chk("post_rst_lat1", 32'(o_dv), 0);
        dv = 0;
        tick();
        chk("post_rst_lat2", 32'(o_dv),   1);
        chk("post_rst_data", 32'(o_data), 32'hB);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            din = 7'($urandom_range(0, 127));
            dv  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 19) == 0);
            tick();
        end
        dv = 0; clr = 0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
